alu_mc: RTL and testbench

- Parametrised multi-cycle successor to the 16-bit combinational ALU in the execute stage.
- Adds iterative unsigned multiply, divide and remainder alongside the existing single-cycle operations.
- Uses a valid/ready handshake on both sides so the pipeline can stall while a long operation runs.
- Sits between decode/operand-read and writeback. One operation in flight at a time.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/alu_mc_if.sv | 36 +++
 rtl/alu_muldiv_iter.sv | 88 ++++++++
 rtl/alu_mc.sv | 128 ++++++++++++
 tb/tb_alu_mc.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared execute-stage types: ALU opcodes and multi-cycle ALU states.
// Extended with iterative MUL/DIVU/REMU codes.
package riscv_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'h0,
    SUB  = 4'h1,
    INV  = 4'h2,
    SLL  = 4'h3,
    SLR  = 4'h4,
    AND  = 4'h5,
    OR   = 4'h6,
    XOR  = 4'h7,
    SLT  = 4'h8,
    MUL  = 4'hA,
    DIVU = 4'hB,
    REMU = 4'hC
  } alu_src_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_state_t;

  function automatic logic is_muldiv(
    input logic [3:0] f
  );
    return (f == MUL) || (f == DIVU) ||
           (f == REMU);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Valid/ready operand and result bundle
// between operand-read, the ALU and writeback.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] rs1_data_i;
  logic [WIDTH-1:0] rs2_data_i;
  logic [WIDTH-1:0] imm_data_i;
  logic             imm_en_i;
  logic             jalr_en_i;
  logic [3:0]       func4;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             busy_o;

  modport master (
    output in_valid_i, rs1_data_i,
    output rs2_data_i, imm_data_i,
    output imm_en_i, jalr_en_i,
    output func4, out_ready_i,
    input  in_ready_o, out_valid_o,
    input  result_o, busy_o
  );

  modport slave (
    input  in_valid_i, rs1_data_i,
    input  rs2_data_i, imm_data_i,
    input  imm_en_i, jalr_en_i,
    input  func4, out_ready_i,
    output in_ready_o, out_valid_o,
    output result_o, busy_o
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned MUL (shift-add) and
// DIVU/REMU (restoring) datapath, one bit per cycle.
module alu_muldiv_iter
  import riscv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic             run;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;

  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] d_n;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;

  // MUL: acc=product, q=multiplier, d=multiplicand.
  // DIV: acc=remainder, q=dividend/quotient, d=divisor.
  always_comb begin
    sh    = {acc, q[WIDTH-1]};
    diff  = sh - {1'b0, d};
    acc_n = acc;
    q_n   = q;
    d_n   = d;
    if (op_q == MUL) begin
      acc_n = q[0] ? acc + d : acc;
      q_n   = q >> 1;
      d_n   = d << 1;
    end else if (!diff[WIDTH]) begin
      acc_n = diff[WIDTH-1:0];
      q_n   = {q[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = sh[WIDTH-1:0];
      q_n   = {q[WIDTH-2:0], 1'b0};
    end
  end

  assign done   = run &&
                  (cnt == SHW'(WIDTH - 1));
  assign result = (op_q == DIVU) ? q_n : acc_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run  <= 1'b0;
      cnt  <= '0;
      op_q <= '0;
      acc  <= '0;
      q    <= '0;
      d    <= '0;
    end else if (flush_i) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run  <= 1'b1;
      cnt  <= '0;
      op_q <= op;
      acc  <= '0;
      q    <= a;
      d    <= b;
    end else if (run) begin
      acc <= acc_n;
      q   <= q_n;
      d   <= d_n;
      cnt <= cnt + 1'b1;
      if (done) begin
        run <= 1'b0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: single-cycle ops, FSM
// and valid/ready handshake around the muldiv unit.
module alu_mc
  import riscv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     flush_i,
  alu_mc_if.slave  bus
);

  alu_state_t       state;
  alu_state_t       state_n;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] md_result;
  logic             md_done;
  logic             is_md;
  logic             accept;
  logic             in_ready;
  logic             out_valid;
  logic             busy;

  assign opb = bus.imm_en_i ? bus.imm_data_i
                            : bus.rs2_data_i;
  assign jalr_sum = bus.rs1_data_i +
                    bus.imm_data_i;
  assign is_md = !bus.jalr_en_i &&
                 is_muldiv(bus.func4);
  assign accept = bus.in_valid_i && in_ready &&
                  !flush_i;

  always_comb begin
    alu_res = '0;
    if (bus.jalr_en_i) begin
      alu_res = {jalr_sum[WIDTH-1:1], 1'b0};
    end else begin
      unique case (bus.func4)
        ADD: alu_res = bus.rs1_data_i + opb;
        SUB: alu_res = bus.rs1_data_i - opb;
        INV: alu_res = ~bus.rs1_data_i;
        SLL: alu_res = bus.rs1_data_i << opb;
        SLR: alu_res = bus.rs1_data_i >> opb;
        AND: alu_res = bus.rs1_data_i & opb;
        OR:  alu_res = bus.rs1_data_i | opb;
        XOR: alu_res = bus.rs1_data_i ^ opb;
        SLT: alu_res = WIDTH'(bus.rs1_data_i < opb);
        default: alu_res = '0;
      endcase
    end
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .start   (accept && is_md),
    .op      (bus.func4),
    .a       (bus.rs1_data_i),
    .b       (opb),
    .done    (md_done),
    .result  (md_result)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (accept)
            state_n = is_md ? BUSY : DONE;
        end
        state == BUSY: begin
          if (md_done) state_n = DONE;
        end
        state == DONE: begin
          if (accept)
            state_n = is_md ? BUSY : DONE;
          else if (bus.out_ready_i)
            state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) ||
                (state == DONE && bus.out_ready_i);
    out_valid = (state == DONE);
    busy      = (state == BUSY);
  end

  // Result is only written on a new single-cycle
  // accept or at the final iteration; stalls hold it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
    end else if (flush_i) begin
      result_q <= '0;
    end else if (accept && !is_md) begin
      result_q <= alu_res;
    end else if (state == BUSY && md_done) begin
      result_q <= md_result;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.busy_o      = busy;
  assign bus.result_o    = result_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc against
// an arithmetic reference model.
module tb_alu_mc;
  import riscv_pkg::*;

  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_alu(
    input logic [3:0]  f,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] imm,
    input logic        ie,
    input logic        jr
  );
    longint unsigned ua, ub, r;
    logic [15:0] ob;
    ob = ie ? imm : b;
    ua = a;
    ub = ob;
    r  = 0;
    if (jr) begin
      r = (ua + imm) % 65536;
      r = r - (r % 2);
    end else begin
      case (f)
        ADD:  r = ua + ub;
        SUB:  r = ua + 65536 - ub;
        INV:  r = 65535 - ua;
        SLL:  r = (ub >= 16) ? 0 : ua * (64'd1 << ub);
        SLR:  r = (ub >= 16) ? 0 : ua / (64'd1 << ub);
        AND:  r = a & ob;
        OR:   r = a | ob;
        XOR:  r = a ^ ob;
        SLT:  r = (ua < ub) ? 1 : 0;
        MUL:  r = ua * ub;
        DIVU: r = (ub == 0) ? 65535 : ua / ub;
        REMU: r = (ub == 0) ? ua : ua % ub;
        default: r = 0;
      endcase
    end
    return 16'(r % 65536);
  endfunction

  task automatic drive(input logic [3:0] f,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [15:0] imm,
                       input logic ie,
                       input logic jr);
    bus.func4      = f;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.imm_data_i = imm;
    bus.imm_en_i   = ie;
    bus.jalr_en_i  = jr;
  endtask

  task automatic scramble();
    bus.func4      = 4'($urandom);
    bus.rs1_data_i = 16'($urandom);
    bus.rs2_data_i = 16'($urandom);
    bus.imm_data_i = 16'($urandom);
    bus.imm_en_i   = 1'($urandom);
    bus.jalr_en_i  = 1'($urandom);
  endtask

  task automatic run_op(input string tag,
                        input logic [3:0] f,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [15:0] imm,
                        input logic ie,
                        input logic jr);
    logic [15:0] exp;
    int exp_lat, lat, nb;
    exp = ref_alu(f, a, b, imm, ie, jr);
    exp_lat = (!jr && (f == MUL || f == DIVU ||
               f == REMU)) ? W + 1 : 1;
    drive(f, a, b, imm, ie, jr);
    bus.in_valid_i = 1'b1;
    #1;
    chk({tag, "_ready"}, bus.in_ready_o, 1);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    scramble();
    lat = 1;
    nb  = 0;
    while (!bus.out_valid_o && lat < 40) begin
      nb += int'(bus.busy_o);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, bus.result_o, exp);
    chk({tag, "_busy"}, nb, exp_lat - 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  initial begin
    logic saw;
    int wait_n;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    drive(4'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    #12;
    chk("rst_in_ready", bus.in_ready_o, 1);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_result", bus.result_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("add_wrap", ADD, 16'hFFFF, 16'h0002,
           16'h0, 1'b0, 1'b0);
    run_op("sll_16", SLL, 16'h1234, 16'h0,
           16'd16, 1'b1, 1'b0);
    run_op("slr_15", SLR, 16'h8000, 16'd15,
           16'h0, 1'b0, 1'b0);
    run_op("slt", SLT, 16'd3, 16'd5,
           16'h0, 1'b0, 1'b0);
    run_op("undef", 4'h9, 16'd3, 16'd5,
           16'h0, 1'b0, 1'b0);
    run_op("mul", MUL, 16'h0123, 16'h0010,
           16'h0, 1'b0, 1'b0);
    run_op("divu", DIVU, 16'd100, 16'd7,
           16'h0, 1'b0, 1'b0);
    run_op("remu", REMU, 16'd100, 16'd7,
           16'h0, 1'b0, 1'b0);
    run_op("divu0", DIVU, 16'd5, 16'd0,
           16'h0, 1'b0, 1'b0);
    run_op("remu0", REMU, 16'd5, 16'd0,
           16'h0, 1'b0, 1'b0);
    run_op("jalr", MUL, 16'h1001, 16'h7777,
           16'h0004, 1'b1, 1'b1);

    // back-pressure then no-bubble accept
    drive(MUL, 16'd7, 16'd9, 16'h0, 1'b0, 1'b0);
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    scramble();
    wait_n = 0;
    while (!bus.out_valid_o && wait_n < 40) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.out_valid_o, 1);
      chk("bp_hold", bus.result_o, 16'd63);
      chk("bp_ready", bus.in_ready_o, 0);
      @(posedge clk);
      #1;
    end
    drive(ADD, 16'd10, 16'd20, 16'h0, 1'b0, 1'b0);
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    #1;
    chk("b2b_ready", bus.in_ready_o, 1);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    chk("b2b_valid", bus.out_valid_o, 1);
    chk("b2b_res", bus.result_o, 16'd30);
    @(posedge clk);
    #1;

    // flush in cycle 8 of a DIVU, with a competing accept
    drive(DIVU, 16'd1000, 16'd3, 16'h0, 1'b0, 1'b0);
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    flush = 1'b1;
    drive(ADD, 16'd1, 16'd1, 16'h0, 1'b0, 1'b0);
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("fl_valid", bus.out_valid_o, 0);
    chk("fl_busy", bus.busy_o, 0);
    chk("fl_ready", bus.in_ready_o, 1);
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid_o) saw = 1'b1;
    end
    chk("fl_no_valid", saw, 0);

    // asynchronous reset mid-MUL
    drive(MUL, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 1'b0);
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_in_ready", bus.in_ready_o, 1);
    chk("ar_out_valid", bus.out_valid_o, 0);
    chk("ar_busy", bus.busy_o, 0);
    chk("ar_result", bus.result_o, 0);
    #3;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid_o) saw = 1'b1;
    end
    chk("ar_no_valid", saw, 0);

    for (int k = 0; k < 80; k++) begin
      logic [3:0]  f;
      logic [15:0] a, b, imm;
      f   = 4'($urandom_range(0, 15));
      a   = 16'($urandom);
      imm = 16'($urandom_range(0, 20));
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(0, 20));
        1: b = 16'h0;
        default: b = 16'($urandom);
      endcase
      run_op("rnd", f, a, b, imm,
             1'($urandom_range(0, 1)),
             $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
